// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: walks each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath enables, muxes and Aluop.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [5:0]         Opcode,
  input  logic               MemReady,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               PCEn,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               AluSrcA,
  output logic [1:0]         AluSrcB,
  output logic [1:0]         Aluop,
  output logic [1:0]         PCSrc,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BRANCH  = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JUMP    = STATE_W'(11),
    IDLE    = STATE_W'(15)
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    Aluop       = 2'b00;
    PCSrc       = 2'b00;
    Illegal     = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        // IR and PC+4 commit only on the cycle the memory actually returns data.
        MemRead = 1'b1;
        AluSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) state_d = DECODE;
      end
      DECODE: begin
        AluSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d = FETCH;
            Illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        state_d = (Opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_d = MEMWB;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) state_d = FETCH;
      end
      EXECUTE: begin
        AluSrcA = 1'b1;
        Aluop   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        AluSrcA     = 1'b1;
        Aluop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
        state_d     = FETCH;
      end
      ADDIEX: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign PCEn  = PCWrite | (PCWriteCond & Zero);
  assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model feeds an expected
// queue of per-cycle {state, outputs}; a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam int W = 22;

  logic       Clk, Reset_n;
  logic [5:0] Opcode;
  logic       MemReady, Zero;
  logic       PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, AluSrcA, Illegal;
  logic [1:0] AluSrcB, Aluop, PCSrc;
  logic [3:0] State;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  logic [5:0] cur_op;

  multicycle_control #(.STATE_W(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode), .MemReady(MemReady), .Zero(Zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
    .Aluop(Aluop), .PCSrc(PCSrc), .Illegal(Illegal), .State(State)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Per-state output table, straight from the state/output listing.
  function automatic logic [W-1:0] model(input logic [3:0] s, input logic mr,
                                         input logic z, input logic ill);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, illo;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, illo} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  begin asb = 2'b11; illo = ill; end
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd9:  begin asa = 1; asb = 2'b10; end
      4'd10: begin rw = 1; end
      4'd11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {s, pcw, pcwc, pcw | (pcwc & z), iord, mrd, mwr, irw, m2r, rdst, rw, asa,
            asb, aop, pcs, illo};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // driver tasks: one call = one clock cycle of stimulus plus its expected response
  task automatic step(input logic [3:0] s, input logic mr, input logic z, input logic ill);
    @(posedge Clk);
    #1;
    Opcode   = cur_op;
    MemReady = mr;
    Zero     = z;
    exp_q.push_back(model(s, mr, z, ill));
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait,
                           input logic bz);
    cur_op = op;
    for (int i = 0; i < fwait; i++) step(4'd0, 1'b0, rb(), 1'b0);
    step(4'd0, 1'b1, rb(), 1'b0);
    step(4'd1, rb(), rb(), !is_legal(op));
    case (op)
      6'b100011: begin
        step(4'd2, rb(), rb(), 1'b0);
        for (int i = 0; i < mwait; i++) step(4'd3, 1'b0, rb(), 1'b0);
        step(4'd3, 1'b1, rb(), 1'b0);
        step(4'd4, rb(), rb(), 1'b0);
      end
      6'b101011: begin
        step(4'd2, rb(), rb(), 1'b0);
        for (int i = 0; i < mwait; i++) step(4'd5, 1'b0, rb(), 1'b0);
        step(4'd5, 1'b1, rb(), 1'b0);
      end
      6'b000000: begin step(4'd6, rb(), rb(), 1'b0); step(4'd7, rb(), rb(), 1'b0); end
      6'b000100: step(4'd8, rb(), bz, 1'b0);
      6'b001000: begin step(4'd9, rb(), rb(), 1'b0); step(4'd10, rb(), rb(), 1'b0); end
      6'b000010: step(4'd11, rb(), rb(), 1'b0);
      default: ;
    endcase
  endtask

  // Reset lands on the cycle the FSM has just entered EXECUTE; outputs must clear at once.
  task automatic reset_mid_execute();
    cur_op = 6'b000000;
    step(4'd0, 1'b1, rb(), 1'b0);
    step(4'd1, rb(), rb(), 1'b0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    exp_q.push_back(model(4'd15, MemReady, Zero, 1'b0));
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    exp_q.push_back(model(4'd15, MemReady, Zero, 1'b0));
  endtask

  // scoreboard monitor
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {State, PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, AluSrcA, AluSrcB, Aluop, PCSrc, Illegal};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle_check t=%0t state got=%0d exp=%0d outs got=%b exp=%b",
                 $time, a[W-1 -: 4], e[W-1 -: 4], a[W-5:0], e[W-5:0]);
      end
    end
  end

  initial begin
    logic [5:0] op;
    logic [5:0] legal_ops[6];
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    Reset_n = 1'b0; MemReady = 1'b0; Zero = 1'b0; Opcode = 6'b0; cur_op = 6'b0;
    @(posedge Clk); #1;
    exp_q.push_back(model(4'd15, 1'b0, 1'b0, 1'b0));
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    exp_q.push_back(model(4'd15, 1'b0, 1'b0, 1'b0));

    run_instr(6'b000000, 0, 0, 1'b0);   // R
    run_instr(6'b100011, 0, 2, 1'b0);   // LW, 2 wait cycles
    run_instr(6'b101011, 0, 0, 1'b0);   // SW
    run_instr(6'b000100, 0, 0, 1'b1);   // BEQ taken
    run_instr(6'b000100, 0, 0, 1'b0);   // BEQ not taken
    run_instr(6'b001000, 0, 0, 1'b0);   // ADDI
    run_instr(6'b000010, 0, 0, 1'b0);   // J
    run_instr(6'b111111, 0, 0, 1'b0);   // illegal
    run_instr(6'b000000, 3, 0, 1'b0);   // fetch stall
    reset_mid_execute();
    run_instr(6'b100011, 1, 1, 1'b0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rb());
      if ($urandom_range(0, 49) == 0) reset_mid_execute();
    end

    repeat (3) @(negedge Clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL queue_drain left=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
